// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: field widths, TX handshake states
// and the Hamming(7,4) encoder used by injector and decoders.
package noc_pkg;

    localparam int DATA_W = 7;
    localparam int ADDR_W = 4;
    localparam int FLIT_W = 11;
    localparam logic [2:0] CORE_ID = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } tx_state_t;

    // Code index i holds Hamming position i+1; parity at 1, 2 and 4.
    function automatic logic [DATA_W-1:0] hamming74_enc(input logic [3:0] m);
        logic [DATA_W-1:0] c;
        c[2] = m[0];
        c[4] = m[1];
        c[5] = m[2];
        c[6] = m[3];
        c[0] = m[0] ^ m[1] ^ m[3];
        c[1] = m[0] ^ m[2] ^ m[3];
        c[3] = m[1] ^ m[2] ^ m[3];
        return c;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous circular FIFO with occupancy count;
// pointers wrap naturally because DEPTH is a power of two.
module flit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 11,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/flit_injector.sv
// Core-to-router transmitter: Hamming-encodes payloads, queues flits
// and sends them over a 4-phase req/ack channel.
module flit_injector
    import noc_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int ENABLE_FAULT = 0,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_payload,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              inj_en,
    input  logic [2:0]        inj_pos,
    output logic              out_req,
    output logic [FLIT_W-1:0] out_data,
    input  logic              out_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_count
);

    localparam int AW = $clog2(DEPTH);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [DATA_W-1:0] code;
    logic [FLIT_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              push;
    logic              pop;
    logic              ack_s1;
    logic              ack_s;
    logic              done;

    always_comb begin
        code = hamming74_enc(in_payload);
        if (ENABLE_FAULT != 0 && inj_en && inj_pos != 3'd0) begin
            code = code ^ (DATA_W'(1) << (inj_pos - 3'd1));
        end
    end

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign pop      = (state == IDLE) && !fifo_empty;
    assign done     = (state == REL) && !ack_s;
    assign out_req  = (state == REQ);
    assign busy     = (state != IDLE) || (fifo_count != '0);

    flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ({code, in_dest}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ack comes from the router's domain; two flops before the FSM sees it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_s1 <= out_ack;
            ack_s  <= ack_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!fifo_empty) state_nxt = REQ;
            REQ:  if (ack_s) state_nxt = REL;
            REL:  if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            sent_count <= '0;
        end else begin
            if (pop) begin
                out_data <= head;
            end
            if (done) begin
                sent_count <= sent_count + CNT_W'(1);
            end
        end
    end

endmodule
